// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between an ALU result producer, the result FIFO and its consumer.
// The FIFO itself connects through the slave modport.
interface alu_result_fifo_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    y;
    logic          c;
    logic          v;
    logic          n;
    logic          z;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [CW-1:0] count;
    logic [1:0]    sticky_flags;
    logic          clr_sticky;
    logic [7:0]    accepted;

    modport master (
        output in_valid, y, c, v, n, z, out_ready, clr_sticky,
        input  in_ready, out_valid, out_data, count, sticky_flags, accepted
    );

    modport slave (
        input  in_valid, y, c, v, n, z, out_ready, clr_sticky,
        output in_ready, out_valid, out_data, count, sticky_flags, accepted
    );
endinterface

// File: rtl/alu_result_fifo.sv
// FIFO of packed ALU results {Y, C, V, N, Z} with sticky carry/overflow tracking
// and a saturating count of accepted results.
module alu_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    alu_result_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    sticky_q, sticky_d;
    logic [7:0]    accepted_q, accepted_d;
    logic          push;
    logic          pop;
    logic [7:0]    wdata;

    // Both handshakes come purely from registered count, so full/empty gating
    // never depends on what the other side is doing this cycle.
    assign push  = bus.in_valid && (count_q != FULL_COUNT);
    assign pop   = bus.out_ready && (count_q != '0);
    assign wdata = {bus.y, bus.c, bus.v, bus.n, bus.z};

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        sticky_d   = sticky_q;
        accepted_d = accepted_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Clear first so a coinciding flag-setting push wins.
        if (bus.clr_sticky) sticky_d = 2'b00;
        if (push)           sticky_d = sticky_d | {bus.c, bus.v};

        if (push && (accepted_q != 8'hFF)) accepted_d = accepted_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sticky_q   <= 2'b00;
            accepted_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sticky_q   <= sticky_d;
            accepted_q <= accepted_d;
        end
    end

    // Storage is deliberately left out of reset; stale entries are unreachable
    // once the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr_q] <= wdata;
    end

    assign bus.in_ready     = (count_q != FULL_COUNT);
    assign bus.out_valid    = (count_q != '0);
    assign bus.out_data     = mem[rd_ptr_q];
    assign bus.count        = count_q;
    assign bus.sticky_flags = sticky_q;
    assign bus.accepted     = accepted_q;
endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of result entries; SHALL be a power of two in 2..16.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream ALU result present this cycle.
REQ-005 Port: in_ready  output  1  block can accept a result this cycle.
REQ-006 Port: y  input  4  ALU result Y[3:0].
REQ-007 Port: c, v, n, z  input  1 each  ALU carry, overflow, negative, zero flags.
REQ-008 Port: out_valid  output  1  head entry available.
REQ-009 Port: out_ready  input  1  consumer accepts head entry this cycle.
REQ-010 Port: out_data  output  8  head entry packed {Y[3:0], C, V, N, Z}.
REQ-011 Port: count  output  clog2(DEPTH)+1  number of stored entries.
REQ-012 Port: sticky_flags  output  2  {any accepted C, any accepted V} since last clear.
REQ-013 Port: clr_sticky  input  1  synchronous clear of sticky_flags.
REQ-014 Port: accepted  output  8  saturating count of accepted results.

Function
REQ-015 Push SHALL occur exactly when in_valid && in_ready; entry {y,c,v,n,z} written at write pointer.
REQ-016 in_ready SHALL equal (count != DEPTH), purely from registered state.
REQ-017 out_valid SHALL equal (count != 0); out_data SHALL be the entry at read pointer (combinational read of storage).
REQ-018 Pop SHALL occur exactly when out_valid && out_ready; read pointer advances by one.
REQ-019 Latency: entry pushed at edge k SHALL appear on out_data with out_valid high after edge k when FIFO was empty; no same-cycle bypass.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-021 Full (count == DEPTH): in_ready low; in_valid ignored even if out_ready high that cycle; entries never overwritten.
REQ-022 Empty (count == 0): out_valid low; out_ready ignored; count never underflows.
REQ-023 Pointers SHALL wrap modulo DEPTH; ordering strictly first-in first-out across wrap.
REQ-024 sticky_flags[1] SHALL set on a push with c=1; sticky_flags[0] on a push with v=1; bits hold until clr_sticky or reset.
REQ-025 clr_sticky coincident with a flag-setting push: set wins (bit reads 1 after the edge).
REQ-026 accepted SHALL increment by one per push and saturate at 255.
REQ-027 out_data while out_valid low is don't-care; verification SHALL NOT check it.

Reset
REQ-028 While rst high: count=0, pointers=0, in_ready=1, out_valid=0, sticky_flags=2'b00, accepted=0; storage contents not reset.
REQ-029 Reset asserted mid-transfer SHALL discard all entries immediately; no push or pop completes on an edge where rst is high.
REQ-030 First push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-031 Single push y=4'hA,c=1,v=0,n=1,z=0, out_ready=0 -> next cycle out_valid=1, out_data=8'hAA, count=1, sticky_flags=2'b10.
REQ-032 Push 4 results y=1,2,3,4 (flags 0), out_ready=0 -> count=4, in_ready=0; fifth in_valid ignored; pop all -> out_data y order 1,2,3,4, then out_valid=0.
REQ-033 Full FIFO, in_valid=1 and out_ready=1 same cycle -> pop only, count=3; next cycle push accepted, count=4.
REQ-034 Continuous push+pop for 10 cycles with count=2 -> count stays 2, outputs in order across pointer wrap, accepted=12 incl. preload.
REQ-035 Push v=1 while clr_sticky=1 -> sticky_flags[0]=1; next cycle clr_sticky=1 alone -> sticky_flags=2'b00.
REQ-036 3 entries stored, assert rst for one cycle mid-pop -> count=0, out_valid=0, in_ready=1, accepted=0; 300 pushes afterwards -> accepted=255.
